// File: rtl/class_potential_integrator_if.sv
// -----------------------------------------------------------------------------
// class_potential_integrator_if
// Purpose : groups the controller/spike inputs and potential/sample_done
//           outputs of the class potential integrator into one bundle.
// Signals : system_state[1:0]  phase code from the system controller
//           spike_in[7:0]      spike vector, bit 2c / 2c+1 = neuron 1 / 2 of class c
//           spike_valid        spike_in qualifier
//           leak_en            enables the periodic leak
//           potential{1,2}_{h,u,s,t}[2:0]  registered membrane potentials
//           sample_done        one-cycle end-of-window pulse
// Modports: master drives inputs (controller/bench), slave is the integrator.
// -----------------------------------------------------------------------------
interface class_potential_integrator_if;
   logic [1:0] system_state;
   logic [7:0] spike_in;
   logic       spike_valid;
   logic       leak_en;
   logic [2:0] potential1_h;
   logic [2:0] potential2_h;
   logic [2:0] potential1_u;
   logic [2:0] potential2_u;
   logic [2:0] potential1_s;
   logic [2:0] potential2_s;
   logic [2:0] potential1_t;
   logic [2:0] potential2_t;
   logic       sample_done;

   modport master (
      output system_state, spike_in, spike_valid, leak_en,
      input  potential1_h, potential2_h, potential1_u, potential2_u,
             potential1_s, potential2_s, potential1_t, potential2_t, sample_done
   );

   modport slave (
      input  system_state, spike_in, spike_valid, leak_en,
      output potential1_h, potential2_h, potential1_u, potential2_u,
             potential1_s, potential2_s, potential1_t, potential2_t, sample_done
   );
endinterface

// File: rtl/class_potential_integrator.sv
// -----------------------------------------------------------------------------
// class_potential_integrator
// Purpose : integrate-and-leak stage for the eight output neurons (two per
//           class h, u, s, t). Accumulates spikes into 3-bit saturating
//           potentials during SAMPLE, leaks them periodically, closes the
//           window after SAMPLE_LEN accepted beats and pulses sample_done.
// Ports   : clk    - system clock
//           rst_n  - asynchronous active-low reset
//           bus    - class_potential_integrator_if.slave (inputs/potentials)
// Params  : SAMPLE_LEN  accepted spike beats per window (1..255)
//           LEAK_PERIOD clock cycles in SAMPLE between leak steps (2..255)
// -----------------------------------------------------------------------------
module class_potential_integrator #(
   parameter int unsigned SAMPLE_LEN  = 64,
   parameter int unsigned LEAK_PERIOD = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   class_potential_integrator_if.slave    bus
);

   localparam logic [1:0] ST_IDLE     = 2'b00;
   localparam logic [1:0] ST_SAMPLE   = 2'b01;
   localparam logic [1:0] ST_UART     = 2'b11;
   localparam logic [1:0] ST_COMPLETE = 2'b10;

   localparam logic [7:0] C_SAMPLE_LEN = 8'(SAMPLE_LEN);
   localparam logic [7:0] C_LEAK_LAST  = 8'(LEAK_PERIOD - 1);

   typedef enum logic {WIN_OPEN = 1'b0, WIN_CLOSED = 1'b1} win_t;

   win_t             r_win,  w_win_nxt;
   logic [7:0]       r_beat, w_beat_nxt;
   logic [7:0]       r_leak, w_leak_nxt;
   logic [7:0][2:0]  r_pot,  w_pot_nxt;
   logic             r_done, w_done_nxt;
   logic             w_leak_fire;

   // Net effect of one cycle on one potential: spike and leak together cancel.
   function automatic logic [2:0] f_pot_step(input logic [2:0] pot,
                                             input logic       spike,
                                             input logic       leak);
      logic [2:0] nxt;
      if (spike && !leak) begin
         nxt = (pot == 3'd7) ? 3'd7 : pot + 3'd1;
      end else if (leak && !spike) begin
         nxt = (pot == 3'd0) ? 3'd0 : pot - 3'd1;
      end else begin
         nxt = pot;
      end
      return nxt;
   endfunction

   // Next-state logic for window, counters, potentials and done pulse.
   always_comb begin
      w_win_nxt   = r_win;
      w_beat_nxt  = r_beat;
      w_leak_nxt  = r_leak;
      w_pot_nxt   = r_pot;
      w_done_nxt  = 1'b0;
      w_leak_fire = 1'b0;
      case (bus.system_state)
         ST_IDLE: begin
            w_pot_nxt  = 24'd0;
            w_beat_nxt = 8'd0;
            w_leak_nxt = 8'd0;
            w_win_nxt  = WIN_OPEN;
         end
         ST_SAMPLE: begin
            if (r_win == WIN_OPEN) begin
               w_leak_fire = bus.leak_en && (r_leak == C_LEAK_LAST);
               for (int i = 0; i < 8; i++) begin
                  w_pot_nxt[i] = f_pot_step(r_pot[i],
                                            bus.spike_valid && bus.spike_in[i],
                                            w_leak_fire);
               end
               // Leak counter only advances while leak is enabled.
               if (bus.leak_en) begin
                  w_leak_nxt = w_leak_fire ? 8'd0 : r_leak + 8'd1;
               end else begin
                  w_leak_nxt = r_leak;
               end
               // The closing beat is still integrated above; the window shuts after it.
               if (bus.spike_valid) begin
                  w_beat_nxt = r_beat + 8'd1;
                  if ((r_beat + 8'd1) == C_SAMPLE_LEN) begin
                     w_win_nxt  = WIN_CLOSED;
                     w_done_nxt = 1'b1;
                  end else begin
                     w_win_nxt  = WIN_OPEN;
                  end
               end else begin
                  w_beat_nxt = r_beat;
               end
            end else begin
               w_win_nxt = WIN_CLOSED;
            end
         end
         ST_UART, ST_COMPLETE: begin
            w_beat_nxt = 8'd0;
            w_leak_nxt = 8'd0;
            w_win_nxt  = WIN_OPEN;
         end
         default: begin
            w_pot_nxt  = 24'd0;
            w_beat_nxt = 8'd0;
            w_leak_nxt = 8'd0;
            w_win_nxt  = WIN_OPEN;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win  <= WIN_OPEN;
         r_beat <= 8'd0;
         r_leak <= 8'd0;
         r_pot  <= 24'd0;
         r_done <= 1'b0;
      end else begin
         r_win  <= w_win_nxt;
         r_beat <= w_beat_nxt;
         r_leak <= w_leak_nxt;
         r_pot  <= w_pot_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign bus.potential1_h = r_pot[0];
   assign bus.potential2_h = r_pot[1];
   assign bus.potential1_u = r_pot[2];
   assign bus.potential2_u = r_pot[3];
   assign bus.potential1_s = r_pot[4];
   assign bus.potential2_s = r_pot[5];
   assign bus.potential1_t = r_pot[6];
   assign bus.potential2_t = r_pot[7];
   assign bus.sample_done  = r_done;

endmodule

// File: tb/tb_class_potential_integrator.sv
// -----------------------------------------------------------------------------
// tb_class_potential_integrator
// Two integrators (window of 64 and of 4 beats, leak period 16) share one
// stimulus stream. An arithmetic reference model predicts every potential and
// sample_done each cycle; directed scenarios also pin literal values.
// -----------------------------------------------------------------------------
module tb_class_potential_integrator;

   localparam int LP = 16;
   localparam logic [1:0] S_IDLE = 2'b00, S_SAMPLE = 2'b01, S_UART = 2'b11, S_COMPLETE = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] st = 2'b00;
   logic [7:0] spk = 8'd0;
   logic       vld = 1'b0;
   logic       len = 1'b0;
   bit         chk_on = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   class_potential_integrator_if if_a();
   class_potential_integrator_if if_b();

   assign if_a.system_state = st;
   assign if_a.spike_in     = spk;
   assign if_a.spike_valid  = vld;
   assign if_a.leak_en      = len;
   assign if_b.system_state = st;
   assign if_b.spike_in     = spk;
   assign if_b.spike_valid  = vld;
   assign if_b.leak_en      = len;

   class_potential_integrator #(.SAMPLE_LEN(64), .LEAK_PERIOD(LP)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   class_potential_integrator #(.SAMPLE_LEN(4), .LEAK_PERIOD(LP)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

   always #5 clk = ~clk;

   logic [7:0][2:0] pa, pb;
   assign pa = {if_a.potential2_t, if_a.potential1_t, if_a.potential2_s, if_a.potential1_s,
                if_a.potential2_u, if_a.potential1_u, if_a.potential2_h, if_a.potential1_h};
   assign pb = {if_b.potential2_t, if_b.potential1_t, if_b.potential2_s, if_b.potential1_s,
                if_b.potential2_u, if_b.potential1_u, if_b.potential2_h, if_b.potential1_h};

   // ---------------- reference model ----------------
   int mpot [2][8];
   int mbeat[2];
   int mleak[2];
   bit mopen[2];
   bit mdone[2];

   function automatic int slen(input int k);
      return (k == 0) ? 64 : 4;
   endfunction

   function automatic int clamp7(input int v);
      return (v < 0) ? 0 : ((v > 7) ? 7 : v);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mpot[k][i] <= 0;
            mbeat[k] <= 0; mleak[k] <= 0; mopen[k] <= 1'b1; mdone[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            mdone[k] <= 1'b0;
            if (st == S_IDLE) begin
               for (int i = 0; i < 8; i++) mpot[k][i] <= 0;
               mbeat[k] <= 0; mleak[k] <= 0; mopen[k] <= 1'b1;
            end else if (st == S_SAMPLE) begin
               if (mopen[k]) begin
                  for (int i = 0; i < 8; i++)
                     mpot[k][i] <= clamp7(mpot[k][i] + int'(vld && spk[i])
                                          - int'(len && (mleak[k] == LP - 1)));
                  if (len) mleak[k] <= (mleak[k] + 1) % LP;
                  if (vld) begin
                     mbeat[k] <= mbeat[k] + 1;
                     if (mbeat[k] + 1 == slen(k)) begin
                        mopen[k] <= 1'b0;
                        mdone[k] <= 1'b1;
                     end
                  end
               end
            end else begin
               mbeat[k] <= 0; mleak[k] <= 0; mopen[k] <= 1'b1;
            end
         end
      end
   end

   task automatic cmp_model(input int k, input logic [7:0][2:0] got, input logic gd);
      logic [7:0][2:0] exp;
      for (int i = 0; i < 8; i++) exp[i] = 3'(mpot[k][i]);
      n_checks++;
      if (got !== exp || gd !== mdone[k]) begin
         n_fail++;
         $display("FAIL model_cmp dut%0d t=%0t got pots=%o done=%b required pots=%o done=%b",
                  k, $time, got, gd, exp, mdone[k]);
      end
   endtask

   // Every-cycle comparison of both DUTs against the model, away from the clock edge.
   always @(negedge clk) begin
      if (chk_on && rst_n) begin
         cmp_model(0, pa, if_a.sample_done);
         cmp_model(1, pb, if_b.sample_done);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h required=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset
      #1 rst_n = 1'b0;
      #1;
      chk("rst_pots_a", 32'(pa), 32'd0);
      chk("rst_pots_b", 32'(pb), 32'd0);
      chk("rst_done_a", 32'(if_a.sample_done), 32'd0);
      step(); step();
      rst_n = 1'b1;
      chk_on = 1'b1;
      step();

      // Saturation: 10 beats on neuron h1, no leak
      st = S_SAMPLE; spk = 8'h01; vld = 1'b1; len = 1'b0;
      repeat (10) step();
      vld = 1'b0; spk = 8'h00;
      chk("sat_a", 32'(pa), 32'd7);
      chk("sat_b_window4", 32'(pb), 32'd4);

      // IDLE clears everything next cycle
      st = S_IDLE;
      step();
      chk("idle_a", 32'(pa), 32'd0);
      chk("idle_b", 32'(pb), 32'd0);
      chk("idle_done_b", 32'(if_b.sample_done), 32'd0);

      // Leak: u1/u2 to 3, then one leak every 16 cycles
      st = S_SAMPLE; len = 1'b1; spk = 8'h0C; vld = 1'b1;
      repeat (3) step();
      vld = 1'b0; spk = 8'h00;
      repeat (12) step();
      chk("leak_pre_u1", 32'(if_a.potential1_u), 32'd3);
      chk("leak_pre_u2", 32'(if_a.potential2_u), 32'd3);
      step();
      chk("leak1_u1", 32'(if_a.potential1_u), 32'd2);
      chk("leak1_u2", 32'(if_a.potential2_u), 32'd2);
      repeat (16) step();
      chk("leak2_u1", 32'(if_a.potential1_u), 32'd1);
      repeat (16) step();
      chk("leak3_u1", 32'(if_a.potential1_u), 32'd0);
      repeat (12) step();
      chk("leak_floor_u2", 32'(if_a.potential2_u), 32'd0);

      // Simultaneous spike and leak at 7 and at 0
      st = S_IDLE; len = 1'b0;
      step();
      st = S_SAMPLE; len = 1'b1; spk = 8'h80; vld = 1'b1;
      repeat (16) step();
      chk("simul_t2_at7", 32'(if_a.potential2_t), 32'd7);
      vld = 1'b0; spk = 8'h00;
      repeat (15) step();
      chk("simul_t2_hold", 32'(if_a.potential2_t), 32'd7);
      spk = 8'h40; vld = 1'b1;
      step();
      vld = 1'b0; spk = 8'h00;
      chk("simul_t1_at0", 32'(if_a.potential1_t), 32'd0);
      chk("simul_t2_leak", 32'(if_a.potential2_t), 32'd6);

      // Window close on the 4-beat instance
      st = S_IDLE; len = 1'b0;
      step();
      st = S_SAMPLE; spk = 8'hFF; vld = 1'b1;
      repeat (4) step();
      chk("win_b_pots", 32'(pb), 32'o44444444);
      chk("win_b_done", 32'(if_b.sample_done), 32'd1);
      chk("win_a_nodone", 32'(if_a.sample_done), 32'd0);
      step();
      chk("win_b_done_pulse", 32'(if_b.sample_done), 32'd0);
      step();
      vld = 1'b0; spk = 8'h00;
      chk("win_b_ignored", 32'(pb), 32'o44444444);
      chk("win_a_six", 32'(pa), 32'o66666666);
      step();
      chk("win_b_no_redone", 32'(if_b.sample_done), 32'd0);

      // Hold in COMPLETE, then resume with a fresh window
      st = S_COMPLETE;
      repeat (5) step();
      chk("hold_b", 32'(pb), 32'o44444444);
      st = S_SAMPLE; spk = 8'h10; vld = 1'b1;
      repeat (2) step();
      vld = 1'b0; spk = 8'h00;
      chk("resume_b", 32'(pb), 32'o44464444);
      chk("resume_a", 32'(pa), 32'o66676666);

      // Asynchronous reset mid-window
      vld = 1'b1; spk = 8'hFF;
      step();
      rst_n = 1'b0;
      #1;
      chk("arst_a", 32'(pa), 32'd0);
      chk("arst_b", 32'(pb), 32'd0);
      chk("arst_done_b", 32'(if_b.sample_done), 32'd0);
      vld = 1'b0; spk = 8'h00; st = S_IDLE;
      step();
      rst_n = 1'b1;
      step();

      // Randomized phases checked against the model
      for (int ph = 0; ph < 150; ph++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r < 13)      st = S_SAMPLE;
         else if (r < 16) st = S_IDLE;
         else if (r < 18) st = S_COMPLETE;
         else             st = S_UART;
         len = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 40)) begin
            vld = ($urandom_range(0, 2) != 0);
            spk = 8'($urandom);
            if ($urandom_range(0, 15) == 0) len = ~len;
            step();
         end
      end
      vld = 1'b0; spk = 8'h00;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
